// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the title/game/lost screen renderers.
// Two free-running counters (hc, vc) walk the raster one pixel per ce=1 clock.
// Every output is a registered decode of the counters, loaded on the same ce=1
// clock that advances them. All outputs therefore share one clock of latency
// and describe the same pixel in every cycle.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Coordinates are 10 bits wide, so neither raster dimension may exceed 1024.
    generate
        if (H_TOTAL > 1024) begin : g_bad_h_total
            $error("vga_timing_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_bad_v_total
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Raster position counters
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;

    // Registered outputs
    logic [9:0] draw_x_q, draw_x_d;
    logic [9:0] draw_y_q, draw_y_d;
    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Set by the first frame start after reset; that frame does not bump frame_cnt.
    logic       started_q, started_d;

    // Decode of the current counter position
    logic h_wrap;
    logic v_wrap;
    logic h_active;
    logic v_active;
    logic h_sync_win;
    logic v_sync_win;
    logic at_line_start;
    logic at_frame_start;

    // Position decode; widened by one bit so a 1024-wide limit compares correctly.
    always_comb begin
        h_wrap         = (hc_q == H_LAST);
        v_wrap         = (vc_q == V_LAST);
        h_active       = ({1'b0, hc_q} < 11'(H_VISIBLE));
        v_active       = ({1'b0, vc_q} < 11'(V_VISIBLE));
        h_sync_win     = ({1'b0, hc_q} >= 11'(H_SYNC_START)) &&
                         ({1'b0, hc_q} <= 11'(H_SYNC_END));
        v_sync_win     = ({1'b0, vc_q} >= 11'(V_SYNC_START)) &&
                         ({1'b0, vc_q} <= 11'(V_SYNC_END));
        at_line_start  = (hc_q == 10'd0);
        at_frame_start = at_line_start && (vc_q == 10'd0);
    end

    // Counter advance: hc steps every ce clock, vc steps when hc wraps.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (ce) begin
            if (h_wrap) begin
                hc_d = 10'd0;
                vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Output next-state: load the decode on ce, otherwise hold; strobes clear on ce=0.
    always_comb begin
        draw_x_d      = draw_x_q;
        draw_y_d      = draw_y_q;
        blank_d       = blank_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        frame_cnt_d   = frame_cnt_q;
        started_d     = started_q;
        line_start_d  = ce && at_line_start;
        frame_start_d = ce && at_frame_start;
        if (ce) begin
            draw_x_d = hc_q;
            draw_y_d = vc_q;
            blank_d  = h_active && v_active;
            hs_d     = h_sync_win ? SYNC_POL : ~SYNC_POL;
            vs_d     = v_sync_win ? SYNC_POL : ~SYNC_POL;
            if (at_frame_start) begin
                started_d = 1'b1;
                if (started_q) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            draw_x_q      <= 10'd0;
            draw_y_q      <= 10'd0;
            blank_q       <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            started_q     <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            started_q     <= started_d;
        end
    end

    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance "dut_a" uses the 640x480 defaults for
// line-level timing, ce gating and async reset. Instance "dut_b" uses a tiny
// 15x12 raster with SYNC_POL=1 so full frames and the frame_cnt wrap fit in a
// short run.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, ce_a, rst_n_b, ce_b;

  logic [9:0] dx_a, dy_a, dx_b, dy_b;
  logic       blank_a, hs_a, vs_a, ls_a, fs_a;
  logic       blank_b, hs_b, vs_b, ls_b, fs_b;
  logic [7:0] fc_a, fc_b;

  vga_timing_gen dut_a (
    .vga_clk     (clk),
    .reset_n     (rst_n_a),
    .ce          (ce_a),
    .DrawX       (dx_a),
    .DrawY       (dy_a),
    .blank       (blank_a),
    .hs          (hs_a),
    .vs          (vs_a),
    .line_start  (ls_a),
    .frame_start (fs_a),
    .frame_cnt   (fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
    .SYNC_POL  (1'b1)
  ) dut_b (
    .vga_clk     (clk),
    .reset_n     (rst_n_b),
    .ce          (ce_b),
    .DrawX       (dx_b),
    .DrawY       (dy_b),
    .blank       (blank_b),
    .hs          (hs_b),
    .vs          (vs_b),
    .line_start  (ls_b),
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
  );

  logic [24:0] obs_a, obs_b;
  assign obs_a = {dx_a, dy_a, blank_a, hs_a, vs_a, ls_a, fs_a};
  assign obs_b = {dx_b, dy_b, blank_b, hs_b, vs_b, ls_b, fs_b};

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int mx, my;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {x, y, blank, hs, vs, line_start, frame_start} for a pixel.
  function automatic logic [24:0] model_vec(input int x, input int y, input int hv,
                                            input int hsb, input int hse, input int vv,
                                            input int vsb, input int vse, input logic pol);
    logic bl, h, v, ls, fs;
    bl = (x < hv) && (y < vv);
    h  = (x >= hsb && x <= hse) ? pol : ~pol;
    v  = (y >= vsb && y <= vse) ? pol : ~pol;
    ls = (x == 0);
    fs = (x == 0) && (y == 0);
    return {10'(x), 10'(y), bl, h, v, ls, fs};
  endfunction

  function automatic logic [24:0] exp_a(input int x, input int y);
    return model_vec(x, y, 640, 656, 751, 480, 490, 491, 1'b0);
  endfunction

  function automatic logic [24:0] exp_b(input int x, input int y);
    return model_vec(x, y, 8, 10, 12, 6, 7, 8, 1'b1);
  endfunction

  task automatic step_model(input int ht, input int vt);
    if (mx == ht - 1) begin
      mx = 0;
      my = (my == vt - 1) ? 0 : my + 1;
    end else begin
      mx = mx + 1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick_a(input logic c);
    ce_a = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic c);
    ce_b = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string pfx);
    check_val({pfx, "_x"}, dx_a, 0);
    check_val({pfx, "_y"}, dy_a, 0);
    check_val({pfx, "_blank"}, blank_a, 0);
    check_val({pfx, "_hs"}, hs_a, 1);
    check_val({pfx, "_vs"}, vs_a, 1);
    check_val({pfx, "_ls"}, ls_a, 0);
    check_val({pfx, "_fs"}, fs_a, 0);
    check_val({pfx, "_fcnt"}, fc_a, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int blank_cnt, hs_cnt, hs_first, hs_last, frames;
    rst_n_a = 1'b0; ce_a = 1'b1;
    rst_n_b = 1'b0; ce_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst");

    // Release with ce=1: first clock presents (0,0) with strobes.
    rst_n_a = 1'b1;
    mx = 0; my = 0;
    blank_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 810; i++) begin
      exp_q.push_back(exp_a(mx, my));
      step_model(800, 525);
      tick_a(1'b1);
      check_val("pix_a", obs_a, exp_q.pop_front());
      if (i == 0) check_val("first_fcnt", fc_a, 0);
      if (i == 800) check_val("wrap_xy", {dx_a, dy_a}, {10'd0, 10'd1});
      if (i < 800) begin
        if (blank_a) blank_cnt++;
        if (!hs_a) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(dx_a);
          hs_last = int'(dx_a);
        end
      end
    end
    check_val("line_blank_cnt", blank_cnt, 640);
    check_val("line_hs_cnt", hs_cnt, 96);
    check_val("hs_first", hs_first, 656);
    check_val("hs_last", hs_last, 751);

    // ce gating around a line wrap.
    for (int i = 0; i < 800 && dx_a != 10'd798; i++) tick_a(1'b1);
    check_val("seek_798", dx_a, 798);
    tick_a(1'b1);
    check_val("x_799", dx_a, 799);
    tick_a(1'b0);
    check_val("hold_x", dx_a, 799);
    check_val("hold_ls", ls_a, 0);
    tick_a(1'b1);
    check_val("ls_on_xy", {dx_a, dy_a}, {10'd0, 10'd2});
    check_val("ls_on", ls_a, 1);
    tick_a(1'b0);
    check_val("ls_drop", ls_a, 0);
    check_val("ls_drop_x", dx_a, 0);
    tick_a(1'b0);
    check_val("ls_stay_low", ls_a, 0);
    tick_a(1'b1);
    check_val("after_gap_x", dx_a, 1);
    check_val("after_gap_ls", ls_a, 0);
    for (int i = 0; i < 40; i++) begin
      tick_a((i % 2) == 0);
      check_val("alt_x", dx_a, 2 + i / 2);
    end

    // Async reset at (300,2), between clock edges.
    for (int i = 0; i < 800 && dx_a != 10'd300; i++) tick_a(1'b1);
    check_val("seek_300", {dx_a, dy_a}, {10'd300, 10'd2});
    check_val("pre_arst_blank", blank_a, 1);
    #2;
    rst_n_a = 1'b0;
    #1;
    check_reset_a("arst");
    tick_a(1'b1);
    tick_a(1'b1);
    check_val("arst_hold_x", dx_a, 0);
    rst_n_a = 1'b1;
    tick_a(1'b1);
    check_val("restart_a", obs_a, exp_a(0, 0));
    check_val("restart_fcnt_a", fc_a, 0);
    rst_n_a = 1'b0;
    ce_a = 1'b0;

    // Small raster, SYNC_POL=1: idle sync level is 0.
    ce_b = 1'b1;
    tick_b(1'b1);
    check_val("b_rst_hs", hs_b, 0);
    check_val("b_rst_vs", vs_b, 0);
    check_val("b_rst_blank", blank_b, 0);
    rst_n_b = 1'b1;
    mx = 0; my = 0; frames = 0;
    for (int i = 0; i < 47000; i++) begin
      exp_q.push_back(exp_b(mx, my));
      step_model(15, 12);
      tick_b(1'b1);
      check_val("pix_b", obs_b, exp_q.pop_front());
      if (fs_b) begin
        frames++;
        check_val("fcnt_b", fc_b, (frames - 1) & 255);
        if (frames == 2) check_val("fcnt_step", fc_b, 1);
        if (frames == 257) begin
          check_val("fcnt_wrap", fc_b, 0);
          break;
        end
      end
    end
    check_val("frames_b", frames, 257);

    // One more frame start (count 1), then reset mid-frame and restart.
    repeat (220) tick_b(1'b1);
    check_val("pre_rst_b_xy", {dx_b, dy_b}, {10'd10, 10'd2});
    check_val("pre_rst_b_fcnt", fc_b, 1);
    #2;
    rst_n_b = 1'b0;
    #1;
    check_val("arst_b_fcnt", fc_b, 0);
    check_val("arst_b_xy", {dx_b, dy_b}, 0);
    check_val("arst_b_hs", hs_b, 0);
    tick_b(1'b1);
    rst_n_b = 1'b1;
    tick_b(1'b1);
    check_val("restart_b", obs_b, exp_b(0, 0));
    check_val("restart_b_fcnt", fc_b, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
